// File: rtl/step_controller_pkg.sv
// Shared types and constants for the step/run controller.
// Holds the controller state encoding and the default debounce counter width.
package step_controller_pkg;

    typedef enum logic [2:0] {
        ST_RESET_HOLD,
        ST_RUN,
        ST_HALT,
        ST_STEP_CYCLE,
        ST_STEP_INSTR
    } state_t;

    // Wide enough for the default of 16 debounce samples (terminal count 15).
    localparam int unsigned DEB_CNT_W = 4;

endpackage

// File: rtl/step_debouncer.sv
// Button debouncer: accepts a new level after DEBOUNCE_CYCLES identical samples
// that differ from the current level; o_rise pulses for one clock on an accepted 0->1.
module step_debouncer
    import step_controller_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = DEB_CNT_W
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            if (i_raw == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= i_raw;
                r_rise  <= i_raw;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule

// File: rtl/step_controller.sv
// CPU run/halt/single-step controller with debounced step and reset buttons.
// Breakpoint comparator and resume bypass are built only with STEP_CONTROLLER_BREAKPOINT_EN.
module step_controller
    import step_controller_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned RESET_CYCLES    = 4
) (
    input  logic        i_oszClk,
    input  logic        i_reset,
    input  logic        i_btnStep,
    input  logic        i_btnReset,
    input  logic        i_swStepNRun,
    input  logic        i_swInstrNCycle,
    input  logic        i_swEnableBreakpoint,
    input  logic [15:0] i_breakpointAddress,
    input  logic [15:0] i_pc,
    input  logic        i_instrFetch,
    output logic        o_cpuClkEn,
    output logic        o_cpuReset,
    output logic        o_halted,
    output logic        o_breakHit
);

    localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [RST_W-1:0] r_rstCnt;
    logic             r_stepFirst;
    logic             w_stepReq;
    logic             w_rstReq;
    logic             w_stepLevel;
    logic             w_rstLevel;
    logic             w_clkEn;
    logic             w_cpuReset;
    logic             w_bpHit;
    logic             w_bpMatch;

    step_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (DEB_W)
    ) u_deb_step (
        .i_clk  (i_oszClk),
        .i_reset(i_reset),
        .i_raw  (i_btnStep),
        .o_level(w_stepLevel),
        .o_rise (w_stepReq)
    );

    step_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (DEB_W)
    ) u_deb_reset (
        .i_clk  (i_oszClk),
        .i_reset(i_reset),
        .i_raw  (i_btnReset),
        .o_level(w_rstLevel),
        .o_rise (w_rstReq)
    );

`ifdef STEP_CONTROLLER_BREAKPOINT_EN
    logic r_bypass;
    logic r_breakHit;

    assign w_bpMatch = i_swEnableBreakpoint && !r_bypass && i_instrFetch
                       && (i_pc == i_breakpointAddress);

    // Bypass lets the halted-on instruction be fetched once after resuming.
    always_ff @(posedge i_oszClk) begin
        if (i_reset) begin
            r_bypass   <= 1'b0;
            r_breakHit <= 1'b0;
        end else begin
            if (r_state == ST_HALT && w_next == ST_RUN) begin
                r_bypass   <= 1'b1;
                r_breakHit <= 1'b0;
            end else begin
                if (w_clkEn && i_instrFetch)
                    r_bypass <= 1'b0;
                if (w_bpHit)
                    r_breakHit <= 1'b1;
            end
        end
    end

    assign o_breakHit = r_breakHit && !i_reset;

    logic w_unused;
    assign w_unused = ^{w_stepLevel, w_rstLevel};
`else
    assign w_bpMatch  = 1'b0;
    assign o_breakHit = 1'b0;

    logic w_unused;
    assign w_unused = ^{w_stepLevel, w_rstLevel, i_swEnableBreakpoint,
                        i_breakpointAddress, i_pc};
`endif

    always_ff @(posedge i_oszClk) begin
        if (i_reset) begin
            r_state     <= ST_RESET_HOLD;
            r_rstCnt    <= '0;
            r_stepFirst <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_stepFirst <= (w_next == ST_STEP_INSTR) && (r_state != ST_STEP_INSTR);
            if (r_state != ST_RESET_HOLD || w_rstReq)
                r_rstCnt <= '0;
            else
                r_rstCnt <= r_rstCnt + 1'b1;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_clkEn    = 1'b0;
        w_cpuReset = 1'b0;
        w_bpHit    = 1'b0;
        case (r_state)
            ST_RESET_HOLD: begin
                w_cpuReset = 1'b1;
                if (r_rstCnt == RST_LAST)
                    w_next = i_swStepNRun ? ST_HALT : ST_RUN;
            end
            ST_RUN: begin
                if (i_swStepNRun) begin
                    w_next = ST_HALT;
                end else if (w_bpMatch) begin
                    w_bpHit = 1'b1;
                    w_next  = ST_HALT;
                end else begin
                    w_clkEn = 1'b1;
                end
            end
            ST_HALT: begin
                if (w_stepReq) begin
                    if (!i_swStepNRun)
                        w_next = ST_RUN;
                    else if (i_swInstrNCycle)
                        w_next = ST_STEP_INSTR;
                    else
                        w_next = ST_STEP_CYCLE;
                end
            end
            ST_STEP_CYCLE: begin
                w_clkEn = 1'b1;
                w_next  = ST_HALT;
            end
            ST_STEP_INSTR: begin
                // First clock always executes; afterwards stop in front of the next fetch.
                if (r_stepFirst || !i_instrFetch)
                    w_clkEn = 1'b1;
                else
                    w_next = ST_HALT;
            end
            default: w_next = ST_RESET_HOLD;
        endcase
        if (w_rstReq)
            w_next = ST_RESET_HOLD;
    end

    assign o_cpuClkEn = w_clkEn && !i_reset;
    assign o_cpuReset = w_cpuReset || i_reset;
    assign o_halted   = (r_state == ST_HALT) || (r_state == ST_RESET_HOLD) || i_reset;

endmodule

// File: tb/tb_step_controller.sv
// Directed bench for step_controller: reset, debounce, instruction step,
// breakpoint/resume (when STEP_CONTROLLER_BREAKPOINT_EN is defined) and button reset.
module tb_step_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        btnStep;
    logic        btnReset;
    logic        swStepNRun;
    logic        swInstr;
    logic        swBp;
    logic [15:0] bpAddr;
    logic [15:0] pc;
    logic        fetch;
    logic        en;
    logic        cpuRst;
    logic        halted;
    logic        bhit;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cyc = '0;
    logic [31:0] cycBase = '0;
    logic [31:0] c0;
    bit          model_on = 1'b0;

    always #5 clk = ~clk;

    // CPU model: counts enabled cycles; a fetch happens every 4th cycle.
    always @(posedge clk) if (en) cyc <= cyc + 1;

    step_controller #(
        .DEBOUNCE_CYCLES(16),
        .RESET_CYCLES   (4)
    ) dut (
        .i_oszClk            (clk),
        .i_reset             (rst),
        .i_btnStep           (btnStep),
        .i_btnReset          (btnReset),
        .i_swStepNRun        (swStepNRun),
        .i_swInstrNCycle     (swInstr),
        .i_swEnableBreakpoint(swBp),
        .i_breakpointAddress (bpAddr),
        .i_pc                (pc),
        .i_instrFetch        (fetch),
        .o_cpuClkEn          (en),
        .o_cpuReset          (cpuRst),
        .o_halted            (halted),
        .o_breakHit          (bhit)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        if (model_on) fetch = ((cyc - cycBase) % 4) == 0;
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; btnStep = 1'b0; btnReset = 1'b0; swStepNRun = 1'b0; swInstr = 1'b0;
        swBp = 1'b0; bpAddr = 16'h0028; pc = 16'h0010; fetch = 1'b0;
        #1;
        chk("in_reset_clken", en, 0);
        chk("in_reset_cpurst", cpuRst, 1);
        tick();
        chk("reset_clken", en, 0);
        chk("reset_cpurst", cpuRst, 1);
        chk("reset_halted", halted, 1);
        chk("reset_breakhit", bhit, 0);
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("hold_cpurst", cpuRst, 1);
            chk("hold_clken", en, 0);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            chk("run_cpurst", cpuRst, 0);
            chk("run_clken", en, 1);
            chk("run_halted", halted, 0);
            tick();
        end
        swStepNRun = 1'b1;
        #1;
        chk("run_to_halt_noen", en, 0);
        tick();
        chk("halt_halted", halted, 1);
        chk("halt_clken", en, 0);

        // Bouncing step button, then a clean hold: one cycle step only.
        c0 = cyc;
        for (int i = 0; i < 40; i++) begin
            btnStep = ((i / 3) % 2) == 0;
            tick();
        end
        chk("bounce_no_pulse", cyc - c0, 0);
        btnStep = 1'b1;
        ticks(22);
        btnStep = 1'b0;
        ticks(20);
        chk("bounce_one_pulse", cyc - c0, 1);
        chk("bounce_halted", halted, 1);

        // Instruction step with a fetch every 4th CPU cycle.
        swInstr = 1'b1;
        cycBase = cyc;
        model_on = 1'b1;
        fetch = 1'b1;
        #1;
        btnStep = 1'b1;
        ticks(30);
        btnStep = 1'b0;
        ticks(20);
        chk("instr_step_enables", cyc - cycBase, 4);
        chk("instr_step_halted", halted, 1);
        chk("instr_step_clken", en, 0);

        // Resume into run mode, then move the PC onto the breakpoint.
        swStepNRun = 1'b0;
        swBp = 1'b1;
        btnStep = 1'b1;
        ticks(30);
        btnStep = 1'b0;
        ticks(20);
        chk("resumed_running", halted, 0);
        pc = 16'h0028;
        #1;
        for (int i = 0; i < 8; i++) begin
            if (fetch) break;
            tick();
        end
        chk("bp_fetch_seen", fetch, 1);
`ifdef STEP_CONTROLLER_BREAKPOINT_EN
        chk("bp_same_clk_en", en, 0);
        c0 = cyc;
        tick();
        chk("bp_breakhit", bhit, 1);
        chk("bp_halted", halted, 1);
        chk("bp_no_advance", cyc - c0, 0);

        btnStep = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!halted) break;
            tick();
        end
        chk("resume_running", halted, 0);
        chk("resume_bypass_en", en, 1);
        chk("resume_bhit_clear", bhit, 0);
        c0 = cyc;
        tick();
        for (int i = 0; i < 8; i++) begin
            if (fetch) break;
            tick();
        end
        chk("rehit_en", en, 0);
        chk("rehit_distance", cyc - c0, 4);
        tick();
        chk("rehit_breakhit", bhit, 1);
        chk("rehit_halted", halted, 1);
        btnStep = 1'b0;
        ticks(20);
`else
        chk("nobp_en", en, 1);
        tick();
        chk("nobp_breakhit", bhit, 0);
        chk("nobp_running", halted, 0);
`endif
        swStepNRun = 1'b1;
        ticks(2);
        chk("step_mode_halted", halted, 1);

        // Long STEP_INSTR (no fetch); reset and step buttons accepted together.
        model_on = 1'b0;
        fetch = 1'b0;
        swInstr = 1'b1;
        btnStep = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!halted) break;
            tick();
        end
        chk("si_entered", halted, 0);
        btnStep = 1'b0;
        ticks(20);
        chk("si_still", halted, 0);
        chk("si_clken", en, 1);
        btnStep = 1'b1;
        btnReset = 1'b1;
        ticks(15);
        chk("si_before_accept", halted, 0);
        tick();
        chk("si_accept_clk", halted, 0);
        chk("si_accept_en", en, 1);
        tick();
        chk("rsthold_en", en, 0);
        chk("rsthold_cpurst", cpuRst, 1);
        chk("rsthold_halted", halted, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rsthold_len", cpuRst, 1);
        end
        tick();
        chk("after_hold_cpurst", cpuRst, 0);
        chk("after_hold_halted", halted, 1);
        chk("after_hold_en", en, 0);
        c0 = cyc;
        ticks(10);
        chk("step_req_ignored", cyc - c0, 0);
        chk("still_halted", halted, 1);
        btnStep = 1'b0;
        btnReset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
